// File: rtl/drink_order_queue_if.sv
// Signal bundle between the order front-end, the user inputs and the step stage.
// The master modport drives the user/step-stage inputs; the slave modport is the queue itself.
interface drink_order_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          order_btn;
  logic [1:0]    drink_sel;
  logic          complete;
  logic          clr_err;
  logic          select;
  logic [1:0]    pos;
  logic          busy;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          timeout;

  modport master (
    output order_btn, drink_sel, complete, clr_err,
    input  select, pos, busy, count, full, overflow, timeout
  );

  modport slave (
    input  order_btn, drink_sel, complete, clr_err,
    output select, pos, busy, count, full, overflow, timeout
  );
endinterface

// File: rtl/drink_order_queue.sv
// Drink order front-end: edge-detects order presses into a small FIFO and issues one order at a
// time to the step stage. Define ORDER_TIMEOUT_EN to add the WAIT_DONE watchdog.
module drink_order_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GAP_CYCLES     = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic               clk,
  input  logic               rst,
  drink_order_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES == 0 ||
      TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("drink_order_queue: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StGap} state_e;

  state_e        state_q, state_d;
  logic          btn_q, cmp_q;
  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    pos_q;
  logic [31:0]   gap_q, gap_d;
  logic          overflow_q, overflow_d;
  logic          push, done, pop, wr_en, full, ovf_set, job_end;

  assign push    = bus.order_btn & ~btn_q;
  assign done    = bus.complete & ~cmp_q;
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (state_q == StIdle) && (count_q != '0);
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  assign overflow_d = ovf_set | (overflow_q & ~bus.clr_err);

`ifdef ORDER_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d, tmo_hit;

  // Watchdog is zero outside WAIT_DONE, so every entry starts a fresh count.
  assign wdog_d    = (state_q == StWaitDone) ? wdog_q + 32'd1 : '0;
  assign tmo_hit   = (state_q == StWaitDone) && !done && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_d = tmo_hit | (timeout_q & ~bus.clr_err);
  assign job_end   = done | tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign job_end     = done;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = StIssue;
      end
      StIssue: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (job_end) begin
          gap_d   = 32'(GAP_CYCLES - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      btn_q      <= 1'b0;
      cmp_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pos_q      <= 2'd0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= bus.order_btn;
      cmp_q      <= bus.complete;
      count_q    <= count_d;
      gap_q      <= gap_d;
      overflow_q <= overflow_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        pos_q    <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= bus.drink_sel;
  end

  assign bus.select   = (state_q == StIssue) & ~rst;
  assign bus.pos      = pos_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
endmodule
